// File: rtl/datapath_sequencer_if.sv
// Instruction handshake and datapath control bus between the sequencer and the 4-bit datapath.
// The sequencer takes the slave modport; the instruction source/datapath side takes master.
interface datapath_sequencer_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 2
) ();
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [N-1:0]      instr_imm;
  logic              instr_cin;

  logic [ADDR_W-1:0] rf_addr;
  logic              rf_we;
  logic              opa_we;
  logic              opb_we;
  logic [2:0]        alu_sel;
  logic              alu_cb_in;
  logic              alu_cb_out;
  logic [N-1:0]      alu_result;
  logic              wb_sel;
  logic [N-1:0]      imm_out;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_cin,
    output alu_cb_out, alu_result,
    input  instr_ready, rf_addr, rf_we, opa_we, opb_we, alu_sel, alu_cb_in, wb_sel, imm_out
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_cin,
    input  alu_cb_out, alu_result,
    output instr_ready, rf_addr, rf_we, opa_we, opb_we, alu_sel, alu_cb_in, wb_sel, imm_out
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle read-read-execute-writeback controller for the 4-bit datapath with carry flag.
// Optional zero flag output flag_z when DPSEQ_ZFLAG_EN is defined.
module datapath_sequencer #(
  parameter int N      = 4,
  parameter int ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  datapath_sequencer_if.slave   bus,
  output logic                  flag_c,
  output logic                  done
`ifdef DPSEQ_ZFLAG_EN
  , output logic                flag_z
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    LAT_A = 3'd2,
    LAT_B = 3'd3,
    EXEC  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_LOADI = 3'b110,
    OP_NOT   = 3'b111
  } op_e;

  state_e            state, state_nxt;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [N-1:0]      imm_q;
  logic              cin_q;
  logic              accept;
  logic              is_arith;
  logic              is_loadi;

  assign accept   = bus.instr_valid && bus.instr_ready;
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_loadi = (op_q == OP_LOADI);
  assign bus.imm_out = imm_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      cin_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= bus.instr_op;
        rd_q  <= bus.instr_rd;
        rs1_q <= bus.instr_rs1;
        rs2_q <= bus.instr_rs2;
        imm_q <= bus.instr_imm;
        cin_q <= bus.instr_cin;
      end
    end
  end

  // Carry/borrow only follows ADD/SUB; logic ops and LOADI leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
    end else if (state == EXEC && is_arith) begin
      flag_c <= bus.alu_cb_out;
    end
  end

`ifdef DPSEQ_ZFLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
    end else if (state == EXEC) begin
      flag_z <= is_loadi ? (imm_q == '0) : (bus.alu_result == '0);
    end
  end
`endif

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.rf_addr     = '0;
    bus.rf_we       = 1'b0;
    bus.opa_we      = 1'b0;
    bus.opb_we      = 1'b0;
    bus.alu_sel     = 3'b000;
    bus.alu_cb_in   = 1'b0;
    bus.wb_sel      = 1'b0;
    done            = 1'b0;

    unique case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (accept) begin
          state_nxt = (bus.instr_op == OP_LOADI) ? EXEC : RD_A;
        end
      end
      RD_A: begin
        bus.rf_addr = rs1_q;
        state_nxt   = LAT_A;
      end
      LAT_A: begin
        bus.opa_we  = 1'b1;
        bus.rf_addr = rs2_q;
        state_nxt   = LAT_B;
      end
      LAT_B: begin
        bus.opb_we = 1'b1;
        state_nxt  = EXEC;
      end
      EXEC: begin
        bus.rf_addr   = rd_q;
        bus.rf_we     = 1'b1;
        done          = 1'b1;
        bus.alu_sel   = op_q;
        bus.wb_sel    = is_loadi;
        bus.alu_cb_in = is_arith & cin_q & flag_c;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
